line_delay_ctrl: RTL and testbench

- Pixel-stream controller that drives the 8-bit × 1024 synchronous FIFO as a one-line delay.
- Writes every incoming pixel into the FIFO. Once one full line is buffered, it reads the FIFO in lockstep with writes.
- Emits each current pixel aligned with the pixel directly above it (previous row), plus row/column indices.
- Feeds the downstream window/filter stages in the image pipeline.

---
 rtl/line_delay_ctrl.sv | 151 +++++++++++++++
 tb/tb_line_delay_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_delay_ctrl.sv
// rtl/line_delay_ctrl.sv - one-line delay controller pairing each pixel with the pixel above it
module line_delay_ctrl #(
    parameter int IMG_WIDTH = 640,
    parameter int DATA_W    = 8,
    parameter int COL_W     = 10,
    parameter int ROW_W     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_vld,
    input  logic [DATA_W-1:0] pix_data,
    output logic              fifo_rst,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_wr_full,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_cur,
    output logic [DATA_W-1:0] out_prev,
    output logic [COL_W-1:0]  out_col,
    output logic [ROW_W-1:0]  out_row,
    output logic              err_ovf,
    output logic              err_udf
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = '1;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              primed;
    logic              frst_hold;
    logic              accept;

    logic [COL_W-1:0]  s1_col;
    logic [ROW_W-1:0]  s1_row;
    logic              s1_primed;

    logic              s2_vld;
    logic [DATA_W-1:0] s2_pix;
    logic [COL_W-1:0]  s2_col;
    logic [ROW_W-1:0]  s2_row;
    logic              s2_primed;

    // fifo_rst is registered, so gating on it adds no input-to-output path
    assign accept = pix_vld && !frame_start && !fifo_rst;

    // fifo reset: held through rst plus one cycle, or two cycles after frame_start
    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_rst  <= 1'b1;
            frst_hold <= 1'b1;
        end else if (frame_start) begin
            fifo_rst  <= 1'b1;
            frst_hold <= 1'b1;
        end else begin
            fifo_rst  <= frst_hold;
            frst_hold <= 1'b0;
        end
    end

    // primed flips on the last pixel of row 0 so reading starts with row 1, column 0
    always_ff @(posedge clk) begin
        if (!rst || frame_start) begin
            col    <= '0;
            row    <= '0;
            primed <= 1'b0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col    <= '0;
                primed <= 1'b1;
                if (row != ROW_MAX) begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            fifo_rd_en   <= 1'b0;
            s1_col       <= '0;
            s1_row       <= '0;
            s1_primed    <= 1'b0;
        end else begin
            fifo_wr_en <= accept;
            fifo_rd_en <= accept && primed;
            if (accept) begin
                fifo_wr_data <= pix_data;
                s1_col       <= col;
                s1_row       <= row;
                s1_primed    <= primed;
            end
        end
    end

    // second stage waits out the FIFO read latency
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_vld    <= 1'b0;
            s2_pix    <= '0;
            s2_col    <= '0;
            s2_row    <= '0;
            s2_primed <= 1'b0;
        end else begin
            s2_vld <= fifo_wr_en && !frame_start;
            if (fifo_wr_en) begin
                s2_pix    <= fifo_wr_data;
                s2_col    <= s1_col;
                s2_row    <= s1_row;
                s2_primed <= s1_primed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_vld  <= 1'b0;
            out_cur  <= '0;
            out_prev <= '0;
            out_col  <= '0;
            out_row  <= '0;
        end else begin
            out_vld <= s2_vld && !frame_start;
            if (s2_vld) begin
                out_cur  <= s2_pix;
                out_prev <= s2_primed ? fifo_rd_data : '0;
                out_col  <= s2_col;
                out_row  <= s2_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || frame_start) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            err_ovf <= err_ovf || (fifo_wr_en && fifo_wr_full);
            err_udf <= err_udf || (fifo_rd_en && fifo_rd_empty);
        end
    end

endmodule

// File: tb/tb_line_delay_ctrl.sv
// tb/tb_line_delay_ctrl.sv - randomized bench for line_delay_ctrl with a FIFO model and row-history reference
module tb_line_delay_ctrl;

    localparam int W       = 4;
    localparam int DW      = 8;
    localparam int CW      = 10;
    localparam int RW      = 4;
    localparam int ROW_MAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_start = 1'b0;
    logic          pix_vld = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          fifo_rst;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_wr_full;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty;
    logic          out_vld;
    logic [DW-1:0] out_cur;
    logic [DW-1:0] out_prev;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;
    logic          err_ovf;
    logic          err_udf;

    line_delay_ctrl #(.IMG_WIDTH(W), .DATA_W(DW), .COL_W(CW), .ROW_W(RW)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_vld(pix_vld), .pix_data(pix_data),
        .fifo_rst(fifo_rst), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_wr_full(fifo_wr_full), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty), .out_vld(out_vld), .out_cur(out_cur), .out_prev(out_prev),
        .out_col(out_col), .out_row(out_row), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 1024-deep synchronous FIFO model with flag injection
    logic [DW-1:0] fmem [0:1023];
    logic [10:0]   wp = '0;
    logic [10:0]   rp = '0;
    logic          empty_inj = 1'b0;
    logic          full_inj = 1'b0;

    assign fifo_rd_empty = (wp == rp) || empty_inj;
    assign fifo_wr_full  = (11'(wp - rp) >= 11'd1024) || full_inj;

    always @(posedge clk) begin
        if (fifo_rst === 1'b1) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (fifo_wr_en === 1'b1) begin
                fmem[wp[9:0]] <= fifo_wr_data;
                wp <= wp + 11'd1;
            end
            if (fifo_rd_en === 1'b1) begin
                fifo_rd_data <= fmem[rp[9:0]];
                if (rp != wp) rp <= rp + 11'd1;
            end
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // reference: pixel n of the frame sits under pixel n-W
    typedef struct {
        int          due;
        logic [7:0]  cur;
        logic [7:0]  prev;
        int          col;
        int          row;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] hist[$];
    int         n = 0;
    int         blocked_until = 0;
    int         rd_cnt = 0;
    bit         mon_en = 1'b0;

    task automatic drop_after(input int c);
        while (expq.size() > 0 && expq[expq.size()-1].due > c) expq.delete(expq.size()-1);
    endtask

    task automatic model_clear(input int c);
        drop_after(c);
        n = 0;
        hist.delete();
        blocked_until = c + 2;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit fs);
        exp_t e;
        pix_vld     = v;
        pix_data    = d;
        frame_start = fs;
        if (fs) begin
            model_clear(cyc);
        end else if (v && cyc > blocked_until) begin
            e.due  = cyc + 3;
            e.cur  = d;
            e.prev = (n >= W) ? hist[n-W] : 8'h00;
            e.col  = n % W;
            e.row  = (n / W > ROW_MAX) ? ROW_MAX : n / W;
            expq.push_back(e);
            hist.push_back(d);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    exp_t mon_e;
    bit   mon_ev;
    always @(negedge clk) begin
        if (mon_en) begin
            while (expq.size() > 0 && expq[0].due < cyc) begin
                mon_e = expq.pop_front();
                check_val("out_due", cyc, mon_e.due);
            end
            mon_ev = expq.size() > 0 && expq[0].due == cyc;
            check_val("out_vld", {31'd0, out_vld}, {31'd0, mon_ev});
            if (mon_ev) begin
                mon_e = expq.pop_front();
                check_val("out_cur",  {24'd0, out_cur},  {24'd0, mon_e.cur});
                check_val("out_prev", {24'd0, out_prev}, {24'd0, mon_e.prev});
                check_val("out_col",  {22'd0, out_col},  mon_e.col);
                check_val("out_row",  {28'd0, out_row},  mon_e.row);
            end
            if (fifo_rd_en) rd_cnt++;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rst = 1'b0;
            model_clear(cyc);
            @(posedge clk);
            #1;
        end
        mon_en = 1'b1;
        check_val("rst_fifo_rst", {31'd0, fifo_rst}, 32'd1);
        check_val("rst_wr_en",    {31'd0, fifo_wr_en}, 32'd0);
        check_val("rst_rd_en",    {31'd0, fifo_rd_en}, 32'd0);
        check_val("rst_err",      {30'd0, err_ovf, err_udf}, 32'd0);
        check_val("rst_out",      {out_cur, out_prev, 6'd0, out_col}, 32'd0);
        rst = 1'b1;
        idle(1);
        check_val("rel_fifo_rst_hold", {31'd0, fifo_rst}, 32'd1);
        idle(1);
        check_val("rel_fifo_rst_end", {31'd0, fifo_rst}, 32'd0);

        // row 0, with a pixel coincident with frame_start that must be dropped
        drive(1'b1, 8'hEE, 1'b1);
        idle(2);
        for (int i = 0; i < W; i++) drive(1'b1, 8'(8'h10 + i), 1'b0);
        idle(4);
        check_val("row0_rd_cnt", rd_cnt, 32'd0);
        check_val("row0_occ", {21'd0, 11'(wp - rp)}, W);

        for (int i = 0; i < W; i++) drive(1'b1, 8'(8'h20 + i), 1'b0);
        idle(4);
        check_val("row1_rd_cnt", rd_cnt, W);
        check_val("row1_occ", {21'd0, 11'(wp - rp)}, W);

        for (int i = 0; i < W; i++) begin
            drive(1'b1, 8'(8'h30 + i), 1'b0);
            idle(1);
        end
        idle(4);
        check_val("row2_occ", {21'd0, 11'(wp - rp)}, W);

        // row 3: injected empty flag on the first read, injected full on the next write
        empty_inj = 1'b1;
        drive(1'b1, 8'h40, 1'b0);
        check_val("udf_early", {31'd0, err_udf}, 32'd0);
        idle(1);
        empty_inj = 1'b0;
        check_val("udf_set", {31'd0, err_udf}, 32'd1);
        check_val("ovf_clear", {31'd0, err_ovf}, 32'd0);
        full_inj = 1'b1;
        drive(1'b1, 8'h41, 1'b0);
        check_val("ovf_early", {31'd0, err_ovf}, 32'd0);
        idle(1);
        full_inj = 1'b0;
        check_val("ovf_set", {31'd0, err_ovf}, 32'd1);
        idle(4);
        check_val("err_sticky", {30'd0, err_ovf, err_udf}, 32'd3);

        drive(1'b0, 8'h00, 1'b1);
        check_val("fs_fifo_rst1", {31'd0, fifo_rst}, 32'd1);
        check_val("fs_err_clear", {30'd0, err_ovf, err_udf}, 32'd0);
        idle(1);
        check_val("fs_fifo_rst2", {31'd0, fifo_rst}, 32'd1);
        idle(1);
        check_val("fs_fifo_rst3", {31'd0, fifo_rst}, 32'd0);
        check_val("fs_occ", {21'd0, 11'(wp - rp)}, 32'd0);

        for (int i = 0; i < 90; i++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(4);

        // reset in mid-row with pixels in flight
        for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        rst = 1'b0;
        pix_vld = 1'b1;
        model_clear(cyc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_val("mid_rst_vld",  {31'd0, out_vld}, 32'd0);
        check_val("mid_rst_fifo", {29'd0, fifo_rst, fifo_wr_en, fifo_rd_en}, 32'd4);
        check_val("mid_rst_data", {out_cur, out_prev, 4'd0, out_row, 8'd0}, 32'd0);
        check_val("mid_rst_col",  {22'd0, out_col}, 32'd0);
        drive(1'b1, 8'h55, 1'b0);
        check_val("mid_rel_hold", {31'd0, fifo_rst}, 32'd1);
        drive(1'b1, 8'h56, 1'b0);
        check_val("mid_rel_end", {31'd0, fifo_rst}, 32'd0);
        for (int i = 0; i < 2 * W; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        idle(6);
        check_val("end_queue_empty", expq.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
